// File: rtl/pc_adder_arb_pkg.sv
// pc_adder_arb_pkg: shared definitions for the PC adder arbiter slice.
//   DEFAULT_WIDTH : default operand/result width in bits.
//   req_id_t      : requester id (1 bit).
//   REQ_SEQ       : id of the sequential PC+4 requester.
//   REQ_BR        : id of the branch-target requester.
package pc_adder_arb_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic req_id_t;

  localparam req_id_t REQ_SEQ = 1'b0;
  localparam req_id_t REQ_BR  = 1'b1;

endpackage

// File: rtl/adder16.sv
// adder16: the shared unsigned adder used in the branch/fetch path.
// The carry-out is discarded, so the sum wraps modulo 2^WIDTH.
// Ports:
//   a, b : operands.
//   sum  : (a + b) mod 2^WIDTH.
module adder16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_adder_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// When both requesters are valid, the one that did not win last time is
// granted. flush suppresses every grant. The last_grant register lives in
// the parent, which updates it only on an actual transfer.
// Ports:
//   valid0, valid1 : requester valids.
//   last_grant     : id granted on the most recent transfer.
//   flush          : kill; forces both grants low.
//   grant0, grant1 : one-hot (or zero) grant.
module rr_arb2
  import pc_adder_arb_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last_grant,
  input  logic    flush,
  output logic    grant0,
  output logic    grant1
);

  // On a tie, requester 0 wins only if requester 1 had the last grant.
  assign grant0 = !flush && valid0 && (!valid1 || (last_grant == REQ_BR));
  assign grant1 = !flush && valid1 && (!valid0 || (last_grant == REQ_SEQ));

endmodule

// File: rtl/pc_adder_arbiter.sv
// pc_adder_arbiter: shares one adder between the sequential PC+4 requester
// (id 0) and the branch-target requester (id 1).
// Two-stage pipeline: stage 1 latches the granted operands, stage 2 adds
// them and registers the sum with a one-cycle response-valid pulse tagged by
// requester. flush kills everything in flight without touching resp_sum or
// the round-robin pointer.
//
// Handshake: a transfer happens on reqN_valid && reqN_ready at a rising
// edge. reqN_ready is combinational from both valids, flush and last_grant
// only; requesters hold valid and operands stable until ready. Responses
// have no backpressure, so one request is accepted per cycle at most.
//
// Optional build macro PC_ADDER_ARBITER_OVF_EN adds resp_ovf, the signed
// two's-complement overflow of the registered add.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset.
//   flush                  : synchronous kill of in-flight operations.
//   req0_valid/a/b/ready   : sequential requester.
//   req1_valid/a/b/ready   : branch requester.
//   resp0_valid/resp1_valid: one-cycle pulse naming the owner of resp_sum.
//   resp_sum               : registered sum, held when no response is valid.
//   resp_ovf               : (PC_ADDER_ARBITER_OVF_EN only) signed overflow.
module pc_adder_arbiter
  import pc_adder_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_sum
`ifdef PC_ADDER_ARBITER_OVF_EN
  ,
  output logic             resp_ovf
`endif
);

  req_id_t          last_grant;
  logic             s1_valid;
  req_id_t          s1_id;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] add_sum;
  logic             xfer;
  req_id_t          grant_id;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .flush      (flush),
    .grant0     (req0_ready),
    .grant1     (req1_ready)
  );

  // Grants are one-hot, so the winner's id is simply grant1.
  assign xfer     = req0_ready || req1_ready;
  assign grant_id = req1_ready ? REQ_BR : REQ_SEQ;

  adder16 #(
    .WIDTH (WIDTH)
  ) u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= REQ_BR;  // requester 0 wins the first tie
      s1_valid    <= 1'b0;
      s1_id       <= REQ_SEQ;
      s1_a        <= '0;
      s1_b        <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_sum    <= '0;
    end else if (flush) begin
      // Ready is low during flush, so nothing new enters; kill stage 1 and
      // the pending response. resp_sum and last_grant keep their values.
      s1_valid    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        last_grant <= grant_id;
        s1_id      <= grant_id;
        s1_a       <= req0_ready ? req0_a : req1_a;
        s1_b       <= req0_ready ? req0_b : req1_b;
      end
      resp0_valid <= s1_valid && (s1_id == REQ_SEQ);
      resp1_valid <= s1_valid && (s1_id == REQ_BR);
      if (s1_valid) begin
        resp_sum <= add_sum;
      end
    end
  end

`ifdef PC_ADDER_ARBITER_OVF_EN
  // Signed overflow: operands share a sign that the sum does not.
  logic ovf_next;
  assign ovf_next = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != s1_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ovf <= 1'b0;
    end else if (flush) begin
      resp_ovf <= 1'b0;
    end else if (s1_valid) begin
      resp_ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_pc_adder_arbiter.sv
module tb_pc_adder_arbiter;
  import pc_adder_arb_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;
  logic         resp0_valid;
  logic         resp1_valid;
  logic [W-1:0] resp_sum;
`ifdef PC_ADDER_ARBITER_OVF_EN
  logic         resp_ovf;
`endif

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic         model_last;
  logic [W-1:0] sum_model;

  pc_adder_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp_sum    (resp_sum)
`ifdef PC_ADDER_ARBITER_OVF_EN
    ,
    .resp_ovf    (resp_ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: sum wraps modulo 2^W; overflow when the true signed sum
  // falls outside the signed W-bit range.
  function automatic exp_t make_exp(input logic id, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input int due);
    exp_t e;
    int   us;
    int   ss;
    us    = int'(a) + int'(b);
    ss    = int'($signed(a)) + int'($signed(b));
    e.id  = id;
    e.sum = W'(us % (1 << W));
    e.ovf = (ss > 32767) || (ss < -32768);
    e.due = due;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic fl, output logic g0, output logic g1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    flush = fl;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!fl) begin
      if (v0 && v1) begin
        if (model_last == REQ_SEQ) g1 = 1'b1;
        else g0 = 1'b1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    if (fl) begin
      // The operation sitting in stage 1 this cycle would respond next cycle.
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].due == cyc + 1) exp_q.delete(i);
    end
    if (g0) begin
      exp_q.push_back(make_exp(REQ_SEQ, a0, b0, cyc + 2));
      model_last = REQ_SEQ;
    end
    if (g1) begin
      exp_q.push_back(make_exp(REQ_BR, a1, b1, cyc + 2));
      model_last = REQ_BR;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, g0, g1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_resp at cycle %0d: got none expected id %0d sum %0h due %0d",
                 cyc, e.id, e.sum, e.due);
      end
      if (resp0_valid || resp1_valid) begin
        check("resp_onehot", {31'b0, resp0_valid & resp1_valid}, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp at cycle %0d: got sum %0h expected no response",
                   cyc, resp_sum);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", {31'b0, resp1_valid}, {31'b0, e.id});
          check("resp_due", cyc, e.due);
          check("resp_sum", {16'b0, resp_sum}, {16'b0, e.sum});
`ifdef PC_ADDER_ARBITER_OVF_EN
          check("resp_ovf", {31'b0, resp_ovf}, {31'b0, e.ovf});
`endif
          sum_model = e.sum;
        end
      end else begin
        check("sum_hold", {16'b0, resp_sum}, {16'b0, sum_model});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic         g0, g1;
    logic         p0, p1;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic         fl;

    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    model_last = REQ_BR;
    sum_model  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp0", {31'b0, resp0_valid}, 0);
    check("rst_resp1", {31'b0, resp1_valid}, 0);
    check("rst_sum", {16'b0, resp_sum}, 0);
    rst = 1'b0;

    // First request after reset.
    drive(1'b1, 16'h0100, 16'h0004, 1'b0, '0, '0, 1'b0, g0, g1);
    idle(3);

    // Wrap on the branch requester; also leaves last_grant = 1.
    drive(1'b0, '0, '0, 1'b1, 16'hFFFE, 16'h0004, 1'b0, g0, g1);
    idle(2);

    // Both valid every cycle: grants alternate starting with 0.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 16'h0010, 16'h0004, 1'b1, 16'h0010, 16'hFFF8, 1'b0, g0, g1);
    idle(3);

    // Signed overflow case.
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, '0, '0, 1'b0, g0, g1);
    idle(3);

    // Flush one cycle after a transfer; req1 held through the flush.
    drive(1'b1, 16'h0200, 16'h0004, 1'b0, '0, '0, 1'b0, g0, g1);
    drive(1'b0, '0, '0, 1'b1, 16'h3000, 16'h0010, 1'b1, g0, g1);
    drive(1'b0, '0, '0, 1'b1, 16'h3000, 16'h0010, 1'b0, g0, g1);
    idle(4);

    // Back-to-back single requester.
    for (int i = 1; i <= 4; i++)
      drive(1'b0, '0, '0, 1'b1, 16'h1000, W'(i), 1'b0, g0, g1);
    idle(3);

    // Random traffic with drops and flushes; operands held until accepted.
    p0 = 1'b0; p1 = 1'b0;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; ra0 = W'($urandom_range(0, 65535)); rb0 = W'($urandom_range(0, 65535));
      end else if (p0 && $urandom_range(0, 15) == 0) begin
        p0 = 1'b0;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; ra1 = W'($urandom_range(0, 65535)); rb1 = W'($urandom_range(0, 65535));
      end else if (p1 && $urandom_range(0, 15) == 0) begin
        p1 = 1'b0;
      end
      fl = ($urandom_range(0, 19) == 0);
      drive(p0, ra0, rb0, p1, ra1, rb1, fl, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    idle(4);

    // Asynchronous reset with two operations in flight.
    drive(1'b1, 16'h0400, 16'h0004, 1'b0, '0, '0, 1'b0, g0, g1);
    drive(1'b0, '0, '0, 1'b1, 16'h0500, 16'h0008, 1'b0, g0, g1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_resp0", {31'b0, resp0_valid}, 0);
    check("mid_rst_resp1", {31'b0, resp1_valid}, 0);
    check("mid_rst_sum", {16'b0, resp_sum}, 0);
    check("mid_rst_ready0", {31'b0, req0_ready}, 0);
    check("mid_rst_ready1", {31'b0, req1_ready}, 0);
    exp_q.delete();
    model_last = REQ_BR;
    sum_model  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    drive(1'b1, 16'h0600, 16'h0004, 1'b1, 16'h0700, 16'h0002, 1'b0, g0, g1);
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_adder_arbiter.md
Name: pc_adder_arbiter

Overview:
- Shares one 16-bit adder between two requesters in the fetch/branch path.
  - Requester 0: sequential PC increment, PC + 4.
  - Requester 1: branch target, PC + sign-extended offset.
- Round-robin arbitration, a two-stage pipeline (operand latch, then add and result register), and a flush for taken branches.
- Sits between the fetch unit / branch unit and the shared adder datapath.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight operations (taken branch / squash).
- req0_valid  input  1  requester 0 presents operands.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid  input  1  requester 1 presents operands.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_ready  output  1  requester 1 accepted this cycle.
- resp0_valid  output  1  one-cycle pulse: resp_sum belongs to requester 0.
- resp1_valid  output  1  one-cycle pulse: resp_sum belongs to requester 1.
- resp_sum  output  WIDTH  registered sum.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst is asynchronous and active-high.
  - While rst is high, all registers clear:
    - s1_valid = 0, s1_id = 0, s1_a = 0, s1_b = 0.
    - resp0_valid = resp1_valid = 0, resp_sum = 0.
    - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready.
  - reqN_ready is combinational from valids, flush and last_grant. It never depends on reqN_a/reqN_b.
  - A requester holds valid and operands stable until ready. A dropped request is legal and simply never granted.
- Arbitration (when flush = 0):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
  - last_grant updates to the granted id only on a transfer.
  - At most one ready is high per cycle.
- No backpressure on responses, so one request can be accepted every cycle. Throughput is 1 per cycle.
- Pipeline:
  - Stage 1, at the edge after transfer: s1_valid = 1, s1_id = granted id, s1_a/s1_b latch the operands.
  - Stage 2, at the next edge: resp_sum = (s1_a + s1_b) mod 2^WIDTH, and resp<s1_id>_valid = s1_valid.
  - Latency is exactly 2 cycles from the transfer edge to the response-valid high.
  - Response valid pulses last one cycle. resp_sum holds its last value while no response is valid.
- Arithmetic: unsigned add with carry-out discarded, so 0xFFFF + 0x0001 = 0x0000. No saturation.
- Flush:
  - While flush = 1, both ready outputs are 0 (no transfer).
  - At that edge, s1_valid and both response valids are cleared.
  - No response is ever produced for an operation in flight during flush.
  - resp_sum and last_grant are unchanged.
- Simultaneous events:
  - A request presented in the same cycle as flush is not accepted and must be re-presented.
  - A response valid asserted in the flush cycle is still visible that cycle; only its successor is killed.
- Reset mid-operation: all in-flight work is discarded and no stale response appears after rst deasserts.

Optional Feature:
- Macro: PC_ADDER_ARBITER_OVF_EN.
- Defined:
  - Adds output port resp_ovf (1 bit).
  - resp_ovf is registered alongside resp_sum and equals the signed two's-complement overflow of s1_a + s1_b: operands of equal sign, sum of different sign.
  - Reset value 0. Cleared by flush together with the response valids.
- Undefined: port absent and no overflow logic is generated.

Decomposition:
- Package pc_adder_arb_pkg holds:
  - Default WIDTH = 16.
  - Requester id constants REQ_SEQ = 0, REQ_BR = 1.
  - The id type (1 bit).
- Sub-module rr_arb2: combinational two-way round-robin grant from (valid0, valid1, last_grant, flush) → (grant0, grant1).
  - The last_grant register stays in the parent.
- The add itself uses the team's existing 16-bit adder block, instantiated in stage 2.

Test Plan:
- Reset release then req0 0x0100 + 0x0004 at cycle 0 → req0_ready = 1 at cycle 0; resp0_valid = 1 with resp_sum = 0x0104 exactly 2 cycles later; resp1_valid stays 0.
- Both valid every cycle:
  - req0 (0x0010, 0x0004) and req1 (0x0010, 0xFFF8).
  - → Grants alternate 0,1,0,1 starting with 0.
  - → Responses alternate 0x0014 / 0x0008, one per cycle.
- Wrap: req1 0xFFFE + 0x0004 → resp_sum = 0x0002.
  - With PC_ADDER_ARBITER_OVF_EN: 0x7FFF + 0x0001 → resp_ovf = 1; 0xFFFE + 0x0004 → resp_ovf = 0.
- Flush one cycle after a req0 transfer of 0x0200 + 0x0004 → no resp0_valid ever for it. A req1 held valid during flush sees ready = 0, then is granted the cycle after and responds 2 cycles later.
- Assert rst asynchronously mid-stream with two operations in flight → all outputs 0 immediately. After release, no response for 3 idle cycles, and the first tie grants requester 0.
- Back-to-back single requester: req1 valid for 4 cycles with B = 1,2,3,4 and A = 0x1000 → 4 consecutive resp1_valid pulses with 0x1001..0x1004, first 2 cycles after the first transfer.
